// File: rtl/pkt_injector_pkg.sv
// Shared definitions for the packet injector: MMIO register map, control and
// status bit positions, FSM state encoding and the byte-to-word helper.
package pkt_injector_pkg;

   localparam logic [31:0] REG_SRC    = 32'h0000_0000;
   localparam logic [31:0] REG_NBYTES = 32'h0000_0004;
   localparam logic [31:0] REG_PERIOD = 32'h0000_0008;
   localparam logic [31:0] REG_CTRL   = 32'h0000_000C;
   localparam logic [31:0] REG_STATUS = 32'h0000_0010;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_IRQ_CLR_BIT = 1;
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_IRQ_BIT     = 1;
   localparam int STAT_OVR_BIT     = 2;

   // 65535 bytes round up to 16384 words, which needs 15 bits
   localparam int WORDS_W = 15;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } inj_state_t;

   function automatic logic [WORDS_W-1:0] bytes_to_words(input logic [15:0] nbytes);
      logic [16:0] rounded;
      rounded = {1'b0, nbytes} + 17'd3;
      return rounded[16:2];
   endfunction

endpackage

// File: rtl/inj_period_timer.sv
// Free-running period timer: pulses fire once every load_value+1 cycles while
// enabled, counting the enabling cycle itself as the first cycle of the period.
module inj_period_timer #(
   parameter int TIMER_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [TIMER_W-1:0] load_value,
   output logic               fire
);

   localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

   logic [TIMER_W-1:0] count;
   logic               enable_q;
   logic               rising;

   assign rising = enable && !enable_q;

   // The rising cycle already counts down once, so a zero period fires right away
   assign fire = enable && (rising ? (load_value == '0) : (count == '0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= enable;
         if (rising) begin
            count <= (load_value == '0) ? '0 : load_value - ONE;
         end else if (enable) begin
            count <= (count == '0) ? load_value : count - ONE;
         end
      end
   end

endmodule

// File: rtl/pkt_injector_ctrl.sv
// MMIO-programmed packet injector: periodically fetches a packet from memory
// one word at a time and streams it to the transmit port, raising irq when done.
module pkt_injector_ctrl
   import pkt_injector_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3039,
   parameter int          TIMER_W   = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mmio_addr_in,
   input  logic [31:0] mmio_data_in,
   input  logic        mmio_wb_in,
   output logic [31:0] mmio_data_out,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        tx_valid_o,
   output logic [31:0] tx_data_o,
   output logic        tx_last_o,
   input  logic        tx_ready_i,
   output logic        irq
);

   localparam logic [WORDS_W-1:0] WORD_ONE = WORDS_W'(1);

   logic [31:0]        src_addr;
   logic [15:0]        nbytes;
   logic [TIMER_W-1:0] period;
   logic               enable;
   logic               overrun;
   logic               fire;
   logic               busy;
   inj_state_t         state;
   logic [WORDS_W-1:0] words_left;

   logic wr_src, wr_nbytes, wr_period, wr_ctrl;

   assign wr_src    = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_SRC);
   assign wr_nbytes = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_NBYTES);
   assign wr_period = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_PERIOD);
   assign wr_ctrl   = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_CTRL);
   assign busy      = (state != IDLE);

   inj_period_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .load_value (period),
      .fire       (fire)
   );

   // Register file; irq and overrun set conditions are last so they beat a clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         src_addr <= '0;
         nbytes   <= '0;
         period   <= '0;
         enable   <= 1'b0;
         irq      <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (wr_src)    src_addr <= {mmio_data_in[31:2], 2'b00};
         if (wr_nbytes) nbytes   <= mmio_data_in[15:0];
         if (wr_period) period   <= mmio_data_in[TIMER_W-1:0];
         if (wr_ctrl) begin
            enable <= mmio_data_in[CTRL_EN_BIT];
            if (mmio_data_in[CTRL_IRQ_CLR_BIT]) begin
               irq     <= 1'b0;
               overrun <= 1'b0;
            end
         end
         if (state == DONE)         irq     <= 1'b1;
         if (fire && state != IDLE) overrun <= 1'b1;
      end
   end

   // Burst engine; mem_addr_o doubles as the shadow source address
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         words_left <= '0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         tx_valid_o <= 1'b0;
         tx_data_o  <= '0;
         tx_last_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fire && nbytes != 16'd0) begin
                  mem_addr_o <= src_addr;
                  words_left <= bytes_to_words(nbytes);
                  mem_req_o  <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (mem_ack_i) begin
                  tx_data_o  <= mem_rdata_i;
                  tx_last_o  <= (words_left == WORD_ONE);
                  tx_valid_o <= 1'b1;
                  mem_req_o  <= 1'b0;
                  mem_addr_o <= mem_addr_o + 32'd4;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (tx_ready_i) begin
                  tx_valid_o <= 1'b0;
                  tx_last_o  <= 1'b0;
                  words_left <= words_left - WORD_ONE;
                  if (words_left == WORD_ONE) begin
                     state <= DONE;
                  end else begin
                     mem_req_o <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mmio_data_out = '0;
      if (mmio_addr_in == BASE_ADDR + REG_SRC) begin
         mmio_data_out = src_addr;
      end else if (mmio_addr_in == BASE_ADDR + REG_NBYTES) begin
         mmio_data_out = {16'd0, nbytes};
      end else if (mmio_addr_in == BASE_ADDR + REG_PERIOD) begin
         mmio_data_out = 32'(period);
      end else if (mmio_addr_in == BASE_ADDR + REG_CTRL) begin
         mmio_data_out[CTRL_EN_BIT] = enable;
      end else if (mmio_addr_in == BASE_ADDR + REG_STATUS) begin
         mmio_data_out[STAT_BUSY_BIT] = busy;
         mmio_data_out[STAT_IRQ_BIT]  = irq;
         mmio_data_out[STAT_OVR_BIT]  = overrun;
      end
   end

endmodule

// File: tb/tb_pkt_injector_ctrl.sv
// Scoreboard bench for pkt_injector_ctrl: expected fetch addresses and tx words
// are queued per burst from the register settings and popped by the monitors.
module tb_pkt_injector_ctrl;

   localparam logic [31:0] BASE     = 32'h0000_3039;
   localparam logic [31:0] OFF_SRC  = 32'h0;
   localparam logic [31:0] OFF_NB   = 32'h4;
   localparam logic [31:0] OFF_PER  = 32'h8;
   localparam logic [31:0] OFF_CTRL = 32'hC;
   localparam logic [31:0] OFF_STAT = 32'h10;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mmio_addr;
   logic [31:0] mmio_data;
   logic        mmio_wb;
   logic [31:0] mmio_rdata;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        tx_valid_o;
   logic [31:0] tx_data_o;
   logic        tx_last_o;
   logic        tx_ready;
   logic        irq;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } tx_exp_t;

   tx_exp_t     tx_exp_q[$];
   logic [31:0] mem_exp_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;
   int bursts_done  = 0;
   int tx_words     = 0;
   int req_cycles   = 0;
   int ready_mode   = 0;
   int stall_left   = 0;
   int word_idx     = 0;
   int fixed_delay  = 0;
   bit ack_rand     = 0;

   pkt_injector_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .mmio_addr_in  (mmio_addr),
      .mmio_data_in  (mmio_data),
      .mmio_wb_in    (mmio_wb),
      .mmio_data_out (mmio_rdata),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack),
      .mem_rdata_i   (mem_rdata),
      .tx_valid_o    (tx_valid_o),
      .tx_data_o     (tx_data_o),
      .tx_last_o     (tx_last_o),
      .tx_ready_i    (tx_ready),
      .irq           (irq)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: event occurred, none expected", name);
   endtask

   // Reference model: a burst reads ceil(n/4) consecutive words from the aligned source
   task automatic pushBurst(input logic [31:0] src, input int nbytes);
      int          words = (nbytes + 3) / 4;
      logic [31:0] a = src & 32'hFFFF_FFFC;
      for (int i = 0; i < words; i++) begin
         mem_exp_q.push_back(a);
         tx_exp_q.push_back('{data: memword(a), last: (i == words - 1)});
         a = a + 32'd4;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] off, input logic [31:0] data);
      @(negedge clock);
      mmio_addr = BASE + off;
      mmio_data = data;
      mmio_wb   = 1'b1;
      @(posedge clock);
      #1;
      mmio_wb = 1'b0;
   endtask

   task automatic readReg(input logic [31:0] off, output logic [31:0] data);
      @(negedge clock);
      mmio_addr = BASE + off;
      #1;
      data = mmio_rdata;
   endtask

   task automatic waitBursts(input int target, input int budget);
      int c = 0;
      while (bursts_done < target && c < budget) begin
         @(posedge clock);
         c++;
      end
      checkOutput("burst_count", 32'(bursts_done), 32'(target));
   endtask

   task automatic finishBurst();
      logic [31:0] rd;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("irq_after_burst", 32'(irq), 32'd1);
      readReg(OFF_STAT, rd);
      checkOutput("status_after_burst", rd, 32'b010);
      applyStimulus(OFF_CTRL, 32'd2);
      checkOutput("irq_cleared", 32'(irq), 32'd0);
      checkOutput("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
      checkOutput("mem_queue_drained", 32'(mem_exp_q.size()), 32'd0);
   endtask

   task automatic runBurst(input logic [31:0] src, input int nbytes, input logic [31:0] period);
      logic [31:0] rd;
      int          target = bursts_done + 1;
      pushBurst(src, nbytes);
      applyStimulus(OFF_SRC, src);
      applyStimulus(OFF_NB, 32'(nbytes));
      applyStimulus(OFF_PER, period);
      readReg(OFF_SRC, rd);
      checkOutput("src_readback", rd, src & 32'hFFFF_FFFC);
      applyStimulus(OFF_CTRL, 32'd1);
      waitBursts(target, 600);
      finishBurst();
   endtask

   // Memory responder and fetch-address monitor
   int          wait_cnt  = 0;
   int          cur_delay = 0;
   bit          have_req  = 0;
   logic [31:0] req_addr;

   always @(negedge clock) begin
      if (!reset) begin
         mem_ack   = 1'b0;
         mem_rdata = '0;
         wait_cnt  = 0;
         have_req  = 0;
      end else if (mem_ack) begin
         mem_ack  = 1'b0;
         have_req = 0;
      end else if (mem_req_o) begin
         req_cycles++;
         checkOutput("no_req_while_tx_valid", 32'(tx_valid_o), 32'd0);
         if (!have_req) begin
            cur_delay = ack_rand ? int'($urandom_range(0, 2)) : fixed_delay;
            req_addr  = mem_addr_o;
            have_req  = 1;
            wait_cnt  = 0;
         end else begin
            checkOutput("mem_addr_stable", mem_addr_o, req_addr);
         end
         if (wait_cnt >= cur_delay) begin
            if (mem_exp_q.size() == 0) failNow("mem_unexpected_req");
            else checkOutput("mem_addr", mem_addr_o, mem_exp_q.pop_front());
            mem_ack   = 1'b1;
            mem_rdata = memword(mem_addr_o);
         end else begin
            wait_cnt++;
         end
      end
   end

   // Transmit sink, hold-stability checker and tx scoreboard
   bit          prev_valid = 0;
   bit          prev_hs    = 0;
   logic [31:0] prev_data;
   logic        prev_last;
   tx_exp_t     mon_e;

   always @(negedge clock) begin
      if (!reset) begin
         prev_valid = 0;
         prev_hs    = 0;
         tx_ready   = 1'b0;
      end else begin
         if (prev_valid && !prev_hs) begin
            checkOutput("tx_valid_held", 32'(tx_valid_o), 32'd1);
            checkOutput("tx_data_held", tx_data_o, prev_data);
            checkOutput("tx_last_held", 32'(tx_last_o), 32'(prev_last));
         end
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 7) != 0);
            2: begin
               if (tx_valid_o && word_idx == 1 && stall_left > 0) begin
                  tx_ready = 1'b0;
                  stall_left--;
               end else begin
                  tx_ready = 1'b1;
               end
            end
            default: tx_ready = 1'b0;
         endcase
         prev_valid = tx_valid_o;
         prev_data  = tx_data_o;
         prev_last  = tx_last_o;
         prev_hs    = tx_valid_o && tx_ready;
         if (prev_hs) begin
            tx_words++;
            if (tx_exp_q.size() == 0) begin
               failNow("tx_unexpected_word");
            end else begin
               mon_e = tx_exp_q.pop_front();
               checkOutput("tx_data", tx_data_o, mon_e.data);
               checkOutput("tx_last", 32'(tx_last_o), 32'(mon_e.last));
               if (mon_e.last) begin
                  bursts_done++;
                  word_idx = 0;
               end else begin
                  word_idx++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      int          k;
      int          b0;
      int          w0;
      int          r0;

      reset     = 1'b0;
      mmio_addr = '0;
      mmio_data = '0;
      mmio_wb   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      tx_ready  = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_mem_req", 32'(mem_req_o), 32'd0);
      checkOutput("reset_tx_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("reset_irq", 32'(irq), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         readReg(32'(i * 4), rd);
         checkOutput("reset_reg_value", rd, 32'd0);
      end

      $display("[TB] basic burst");
      pushBurst(32'd67890, 12);
      applyStimulus(OFF_SRC, 32'd67890);
      applyStimulus(OFF_NB, 32'd12);
      applyStimulus(OFF_PER, 32'd30);
      applyStimulus(OFF_CTRL, 32'd1);
      k = 0;
      while (!mem_req_o && k < 100) begin
         @(posedge clock);
         #1;
         k++;
      end
      checkOutput("fire_latency", 32'(k), 32'd31);
      k = 0;
      while (!irq && k < 100) begin
         @(posedge clock);
         #1;
         k++;
      end
      checkOutput("req_to_irq_cycles", 32'(k), 32'd7);
      readReg(OFF_STAT, rd);
      checkOutput("basic_status", rd, 32'b010);
      checkOutput("basic_bursts", 32'(bursts_done), 32'd1);
      applyStimulus(OFF_CTRL, 32'd2);
      checkOutput("basic_irq_cleared", 32'(irq), 32'd0);
      readReg(OFF_STAT, rd);
      checkOutput("basic_status_cleared", rd, 32'd0);

      $display("[TB] backpressure");
      ready_mode = 2;
      stall_left = 5;
      runBurst(32'h0000_1000, 12, 32'd30);
      checkOutput("stall_consumed", 32'(stall_left), 32'd0);

      $display("[TB] edge sizes and randomized bursts");
      ready_mode = 1;
      ack_rand   = 1;
      runBurst(32'hFFFF_FFF9, 16, 32'd90);
      runBurst(32'h0000_2222, 5, 32'd90);
      for (int i = 0; i < 6; i++) begin
         runBurst($urandom, int'($urandom_range(1, 32)), 32'($urandom_range(80, 120)));
      end

      $display("[TB] nbytes shadowing");
      b0 = bursts_done;
      pushBurst(32'h0000_3000, 8);
      pushBurst(32'h0000_3000, 16);
      applyStimulus(OFF_SRC, 32'h0000_3000);
      applyStimulus(OFF_NB, 32'd8);
      applyStimulus(OFF_PER, 32'd80);
      applyStimulus(OFF_CTRL, 32'd1);
      k = 0;
      while (!mem_req_o && k < 200) begin
         @(posedge clock);
         #1;
         k++;
      end
      checkOutput("shadow_burst_started", 32'(mem_req_o), 32'd1);
      applyStimulus(OFF_NB, 32'd16);
      waitBursts(b0 + 2, 800);
      finishBurst();

      $display("[TB] overrun");
      ack_rand    = 0;
      fixed_delay = 3;
      ready_mode  = 0;
      b0 = bursts_done;
      w0 = tx_words;
      for (int i = 0; i < 30; i++) pushBurst(32'h0000_4000, 40);
      applyStimulus(OFF_SRC, 32'h0000_4000);
      applyStimulus(OFF_NB, 32'd40);
      applyStimulus(OFF_PER, 32'd2);
      applyStimulus(OFF_CTRL, 32'd1);
      repeat (300) @(posedge clock);
      applyStimulus(OFF_CTRL, 32'd0);
      k = 0;
      rd = 32'd1;
      while (rd[0] && k < 300) begin
         readReg(OFF_STAT, rd);
         k++;
      end
      checkOutput("overrun_busy_drained", 32'(rd[0]), 32'd0);
      checkOutput("overrun_flag", 32'(rd[2]), 32'd1);
      checkOutput("overrun_multi_burst", 32'((bursts_done - b0) >= 2), 32'd1);
      checkOutput("overrun_whole_bursts", 32'((tx_words - w0) % 10), 32'd0);
      checkOutput("overrun_req_vs_tx", 32'(mem_exp_q.size()), 32'(tx_exp_q.size()));
      tx_exp_q.delete();
      mem_exp_q.delete();
      applyStimulus(OFF_CTRL, 32'd2);
      readReg(OFF_STAT, rd);
      checkOutput("overrun_cleared", rd, 32'd0);

      $display("[TB] zero length");
      fixed_delay = 0;
      r0 = req_cycles;
      applyStimulus(OFF_SRC, 32'h0000_5000);
      applyStimulus(OFF_NB, 32'd0);
      applyStimulus(OFF_PER, 32'd0);
      applyStimulus(OFF_CTRL, 32'd1);
      repeat (100) @(posedge clock);
      #1;
      checkOutput("zero_len_no_req", 32'(req_cycles - r0), 32'd0);
      checkOutput("zero_len_no_irq", 32'(irq), 32'd0);
      readReg(OFF_STAT, rd);
      checkOutput("zero_len_status", rd, 32'd0);
      applyStimulus(OFF_CTRL, 32'd0);

      $display("[TB] reset mid-send");
      ready_mode = 3;
      pushBurst(32'h0000_6000, 40);
      applyStimulus(OFF_SRC, 32'h0000_6000);
      applyStimulus(OFF_NB, 32'd40);
      applyStimulus(OFF_PER, 32'd5);
      applyStimulus(OFF_CTRL, 32'd1);
      k = 0;
      while (!tx_valid_o && k < 100) begin
         @(posedge clock);
         #1;
         k++;
      end
      checkOutput("reached_send", 32'(tx_valid_o), 32'd1);
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("abort_mem_req", 32'(mem_req_o), 32'd0);
      checkOutput("abort_mem_addr", mem_addr_o, 32'd0);
      checkOutput("abort_tx_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("abort_tx_data", tx_data_o, 32'd0);
      checkOutput("abort_tx_last", 32'(tx_last_o), 32'd0);
      checkOutput("abort_irq", 32'(irq), 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      tx_exp_q.delete();
      mem_exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         readReg(32'(i * 4), rd);
         checkOutput("post_reset_reg", rd, 32'd0);
      end
      r0 = req_cycles;
      repeat (50) @(posedge clock);
      #1;
      checkOutput("post_reset_no_req", 32'(req_cycles - r0), 32'd0);
      checkOutput("post_reset_no_tx", 32'(tx_valid_o), 32'd0);
      checkOutput("post_reset_no_irq", 32'(irq), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/pkt_injector_ctrl.md
# pkt_injector_ctrl

MMIO-configured packet injection scheduler for the packet simulator. The CPU programs a source address, byte count and period; the block then periodically fetches the packet from memory one 32-bit word at a time and streams it onto the network transmit port. It raises `irq` when a packet is complete. It sits between the CPU MMIO bus, the memory read port and the router/NI transmit side.

## Interface
- `BASE_ADDR`, default 32'h0000_3039: MMIO base address; registers are at BASE+0/4/8/C/10.
- `TIMER_W`, default 32: width of the period counter.
- `clock`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mmio_addr_in`  in  32  MMIO address.
- `mmio_data_in`  in  32  MMIO write data.
- `mmio_wb_in`  in  1  MMIO write strobe; single-cycle write.
- `mmio_data_out`  out  32  read data for `mmio_addr_in`; combinational; 0 for unmapped addresses.
- `mem_req_o`  out  1  memory read request.
- `mem_addr_o`  out  32  word-aligned read address.
- `mem_ack_i`  in  1  read acknowledge; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  read data.
- `tx_valid_o`  out  1  transmit word valid.
- `tx_data_o`  out  32  transmit word.
- `tx_last_o`  out  1  marks the final word of the packet.
- `tx_ready_i`  in  1  sink accepts the word.
- `irq`  out  1  level interrupt: packet done.

## Operation
- Registers:
  - SRC_ADDR (+0): bits [1:0] are read as 0.
  - NBYTES (+4): 16 bits.
  - PERIOD (+8): `TIMER_W` bits.
  - CTRL (+C): bit0 `enable`; a write of bit1=1 clears `irq` and is self-clearing.
  - STATUS (+10, read-only): bit0 `busy`, bit1 `irq`, bit2 `overrun`. Overrun is sticky; it clears on a CTRL write with bit1=1.
- Reset values: all registers 0; all outputs 0.
- Timer:
  - Loads PERIOD when `enable` goes 0->1.
  - Decrements each cycle while enabled.
  - At 0 it issues a `fire` and reloads PERIOD.
  - PERIOD=0 means a fire every cycle.
  - When `enable`=0 the timer holds.
- On `fire`:
  - In IDLE: latch shadow copies of SRC_ADDR and NBYTES, set `words = ceil(NBYTES/4)`, go to FETCH. If NBYTES=0, stay in IDLE: no transfer, no irq.
  - Not in IDLE: set `overrun` and skip the burst.
- FSM:
  - IDLE -> FETCH on fire.
  - FETCH: assert `mem_req_o` with `mem_addr_o` = shadow address. On `mem_ack_i`, capture the data into a one-word buffer, advance the address by 4, go to SEND.
  - SEND: assert `tx_valid_o`; `tx_last_o` is asserted when the remaining count is 1. On `tx_ready_i`, decrement the count. If the count reaches 0, go to DONE; otherwise go to FETCH.
  - DONE: set `irq`, go to IDLE (one cycle).
- Handshakes:
  - `mem_req_o`/`mem_addr_o` hold stable until ack.
  - `tx_valid_o`/`tx_data_o`/`tx_last_o` hold stable until ready.
  - `tx_valid_o` never drops without a handshake.
- Config writes during a burst update the registers only. The active burst uses its shadow copies.
- `enable` cleared mid-burst: the burst completes. No new fires occur.
- `irq` set and clear in the same cycle: set wins.
- Reset mid-burst: abort immediately. All outputs go to 0, FSM goes to IDLE, and no partial `tx_last_o` is issued.
- Address arithmetic is modulo 2^32. Wrap at 32'hFFFF_FFFC goes to 0 and is not flagged.

## Timing
- MMIO write takes effect the cycle after the `mmio_wb_in` edge. Reads are same-cycle combinational.
- Fire timing: fire occurs PERIOD+1 cycles after the enable write, then every PERIOD+1 cycles.
- Fire -> `mem_req_o` high: 1 cycle.
- `mem_ack_i` -> `tx_valid_o` high: 1 cycle.
- tx handshake -> next `mem_req_o`: 1 cycle.
- With zero-wait ack and an always-ready sink, each word takes 2 cycles.
- Last handshake -> `irq` high: 2 cycles (via DONE). `busy` is high from FETCH entry through DONE.

## Structure
- Package `pkt_injector_pkg`:
  - register offset constants: `REG_SRC`, `REG_NBYTES`, `REG_PERIOD`, `REG_CTRL`, `REG_STATUS`;
  - CTRL/STATUS bit indices;
  - FSM state enum `inj_state_t` (IDLE, FETCH, SEND, DONE).
- One sub-module, `inj_period_timer`: enable, load value, fire output. The register file, FSM and datapath stay in the top module.

## Test plan
- Basic burst:
  - Stimulus: write SRC=67890, NBYTES=12, PERIOD=30, CTRL=1; memory returns addr-based data; ready always high.
  - Response: reads at 67888, 67892, 67896; 3 tx words with `tx_last_o` on the 3rd; `irq`=1; STATUS=0b010.
- Backpressure: `tx_ready_i` low for 5 cycles on word 2 -> `tx_data_o` holds; no extra `mem_req_o`; 3 words total.
- Overrun: PERIOD=2, NBYTES=40, mem ack delay 3 -> STATUS.overrun=1; each burst is 10 words with no interleaving.
- Edge sizes:
  - NBYTES=0 -> no `mem_req_o` and no irq over 100 cycles.
  - NBYTES=5 -> 2 words.
- Clear and shadowing:
  - CTRL write 0b10 -> `irq`=0.
  - NBYTES rewritten mid-burst -> the current burst keeps the old count; the next burst uses the new one.
- Reset mid-SEND: `reset`=0 -> all outputs are 0 in the same cycle; after release, registers are 0 and nothing fires.
